// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream and back-end strobe bundle between the UART receiver, the
// command decoder and the register file / ALU.
interface uart_cmd_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  RX_ERR;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  FRAME_ERR;

    modport master (
        output RX_P_DATA, RX_D_VLD, RX_ERR,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, FRAME_ERR
    );

    modport slave (
        input  RX_P_DATA, RX_D_VLD, RX_ERR,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, FRAME_ERR
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses UART command frames into register-file and ALU strobes.
// Optional inter-byte timeout is built only when CMD_TIMEOUT_EN is defined.
module uart_cmd_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic              clk,
    input  logic              RST,
    uart_cmd_decoder_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] CMD_WR    = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU   = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_N = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wr_en,  w_wr_en;
    logic                  r_rd_en,  w_rd_en;
    logic                  r_alu_en, w_alu_en;
    logic                  r_ferr,   w_ferr;
    logic [ADDR_WIDTH-1:0] r_addr,   w_addr;
    logic [DATA_WIDTH-1:0] r_wdata,  w_wdata;
    logic [FUN_WIDTH-1:0]  r_fun,    w_fun;
    logic                  w_tmo;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_tmo_cnt;

    // Fires on the edge that would bring the count to TIMEOUT_CYCLES; a byte
    // arriving on that same edge wins and suppresses the timeout.
    assign w_tmo = (r_state != IDLE) && !bus.RX_D_VLD &&
                   (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            r_tmo_cnt <= '0;
        else if (bus.RX_D_VLD || (r_state == IDLE) || w_tmo)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_alu_en    = 1'b0;
        w_ferr      = 1'b0;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_fun       = r_fun;

        if (bus.RX_D_VLD) begin
            if (bus.RX_ERR) begin
                w_ferr      = 1'b1;
                w_state_nxt = IDLE;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.RX_P_DATA == CMD_WR)         w_state_nxt = WR_ADDR;
                        else if (bus.RX_P_DATA == CMD_RD)    w_state_nxt = RD_ADDR;
                        else if (bus.RX_P_DATA == CMD_ALU)   w_state_nxt = ALU_A;
                        else if (bus.RX_P_DATA == CMD_ALU_N) w_state_nxt = ALU_FUN;
                        else                                 w_ferr      = 1'b1;
                    end
                    WR_ADDR: begin
                        w_addr      = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        w_state_nxt = WR_DATA;
                    end
                    WR_DATA: begin
                        w_wdata     = bus.RX_P_DATA;
                        w_wr_en     = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    RD_ADDR: begin
                        w_addr      = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        w_rd_en     = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    // ALU operands land in register-file slots 0 and 1
                    ALU_A: begin
                        w_addr      = '0;
                        w_wdata     = bus.RX_P_DATA;
                        w_wr_en     = 1'b1;
                        w_state_nxt = ALU_B;
                    end
                    ALU_B: begin
                        w_addr      = ADDR_WIDTH'(1);
                        w_wdata     = bus.RX_P_DATA;
                        w_wr_en     = 1'b1;
                        w_state_nxt = ALU_FUN;
                    end
                    ALU_FUN: begin
                        w_fun       = bus.RX_P_DATA[FUN_WIDTH-1:0];
                        w_alu_en    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end else if (w_tmo) begin
            w_ferr      = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_alu_en <= 1'b0;
            r_ferr   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_fun    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_en  <= w_wr_en;
            r_rd_en  <= w_rd_en;
            r_alu_en <= w_alu_en;
            r_ferr   <= w_ferr;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_fun    <= w_fun;
        end
    end

    assign bus.WrEn      = r_wr_en;
    assign bus.RdEn      = r_rd_en;
    assign bus.ALU_EN    = r_alu_en;
    assign bus.FRAME_ERR = r_ferr;
    assign bus.Address   = r_addr;
    assign bus.WrData    = r_wdata;
    assign bus.ALU_FUN   = r_fun;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder; strobe nibble is {WrEn,RdEn,ALU_EN,FRAME_ERR}.
module tb_uart_cmd_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus ();

    uart_cmd_decoder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .RST(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {bus.WrEn, bus.RdEn, bus.ALU_EN, bus.FRAME_ERR};
    endfunction

    // Apply one cycle of input, then look just after the sampling edge.
    task automatic step(input logic v, input logic [7:0] b, input logic e);
        bus.RX_D_VLD  = v;
        bus.RX_P_DATA = b;
        bus.RX_ERR    = e;
        @(posedge clk);
        #1;
        bus.RX_D_VLD  = 1'b0;
        bus.RX_ERR    = 1'b0;
    endtask

    task automatic exp_s(input string tag, input logic [3:0] s);
        chk(tag, 32'(strobes()), 32'(s));
    endtask

    task automatic exp_f(input string tag, input logic [3:0] s, input logic [3:0] a,
                         input logic [7:0] w, input logic [3:0] f);
        chk(tag, {12'h0, strobes(), bus.Address, bus.WrData, bus.ALU_FUN},
                 {12'h0, s, a, w, f});
    endtask

    initial begin
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = 8'h00;
        bus.RX_ERR    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_f("reset", 4'h0, 4'h0, 8'h00, 4'h0);
        rst = 1'b0;

        // Write frame
        step(1, 8'hAA, 0); exp_s("wr_cmd", 4'h0);
        step(1, 8'h05, 0); exp_f("wr_addr", 4'h0, 4'h5, 8'h00, 4'h0);
        step(1, 8'h3C, 0); exp_f("wr_data", 4'h8, 4'h5, 8'h3C, 4'h0);
        step(0, 8'h00, 0); exp_s("wr_done", 4'h0);

        // Read frame, upper nibble of address ignored
        step(1, 8'hBB, 0); exp_s("rd_cmd", 4'h0);
        step(1, 8'hF7, 0); exp_f("rd_addr", 4'h4, 4'h7, 8'h3C, 4'h0);
        step(0, 8'h00, 0); exp_s("rd_done", 4'h0);

        // ALU with operands, back-to-back bytes
        step(1, 8'hCC, 0); exp_s("alu_cmd", 4'h0);
        step(1, 8'h12, 0); exp_f("alu_a", 4'h8, 4'h0, 8'h12, 4'h0);
        step(1, 8'h34, 0); exp_f("alu_b", 4'h8, 4'h1, 8'h34, 4'h0);
        step(1, 8'h02, 0); exp_f("alu_fun", 4'h2, 4'h1, 8'h34, 4'h2);
        step(0, 8'h00, 0); exp_s("alu_done", 4'h0);

        // ALU without operands
        step(1, 8'hDD, 0); exp_s("alun_cmd", 4'h0);
        step(1, 8'h09, 0); exp_f("alun_fun", 4'h2, 4'h1, 8'h34, 4'h9);

        // Illegal command byte, then a read proves we stayed in IDLE
        step(1, 8'h55, 0); exp_f("bad_cmd", 4'h1, 4'h1, 8'h34, 4'h9);
        step(1, 8'hBB, 0); exp_s("bad_rd_cmd", 4'h0);
        step(1, 8'h0A, 0); exp_f("bad_rd_addr", 4'h4, 4'hA, 8'h34, 4'h9);

        // RX_ERR on the data byte drops the write
        step(1, 8'hAA, 0); exp_s("err_wr_cmd", 4'h0);
        step(1, 8'h03, 0); exp_s("err_wr_addr", 4'h0);
        step(1, 8'h77, 1); exp_f("err_wr_data", 4'h1, 4'h3, 8'h34, 4'h9);
        step(1, 8'hBB, 0); exp_s("post_err_cmd", 4'h0);
        step(1, 8'h03, 0); exp_f("post_err_rd", 4'h4, 4'h3, 8'h34, 4'h9);

        // RX_ERR on an otherwise valid command byte in IDLE
        step(1, 8'hAA, 1); exp_s("idle_err", 4'h1);
        step(1, 8'hBB, 0); exp_s("idle_err_cmd", 4'h0);
        step(1, 8'h0C, 0); exp_f("idle_err_rd", 4'h4, 4'hC, 8'h34, 4'h9);

        // Upper bits of function byte ignored
        step(1, 8'hDD, 0); exp_s("fun_hi_cmd", 4'h0);
        step(1, 8'hF3, 0); exp_f("fun_hi", 4'h2, 4'hC, 8'h34, 4'h3);

        // Reset in the middle of an ALU frame
        step(1, 8'hCC, 0); exp_s("rst_cmd", 4'h0);
        step(1, 8'h11, 0); exp_f("rst_a", 4'h8, 4'h0, 8'h11, 4'h3);
        rst = 1'b1;
        #1;
        exp_f("rst_async", 4'h0, 4'h0, 8'h00, 4'h0);
        step(0, 8'h00, 0); exp_f("rst_hold", 4'h0, 4'h0, 8'h00, 4'h0);
        rst = 1'b0;
        step(1, 8'hAA, 0); exp_s("post_rst_cmd", 4'h0);
        step(1, 8'h01, 0); exp_s("post_rst_addr", 4'h0);
        step(1, 8'hFF, 0); exp_f("post_rst_wr", 4'h8, 4'h1, 8'hFF, 4'h0);
        step(0, 8'h00, 0); exp_s("post_rst_done", 4'h0);

`ifdef CMD_TIMEOUT_EN
        // 16 idle cycles mid-frame: timeout on the 16th
        step(1, 8'hAA, 0); exp_s("tmo_cmd", 4'h0);
        for (int i = 1; i < 16; i++) begin
            step(0, 8'h00, 0); exp_s($sformatf("tmo_wait%0d", i), 4'h0);
        end
        step(0, 8'h00, 0); exp_s("tmo_fire", 4'h1);
        step(1, 8'hBB, 0); exp_s("tmo_rd_cmd", 4'h0);
        step(1, 8'h02, 0); exp_f("tmo_rd", 4'h4, 4'h2, 8'hFF, 4'h0);

        // A byte on the 16th cycle keeps the frame alive
        step(1, 8'hAA, 0); exp_s("tmo_edge_cmd", 4'h0);
        for (int i = 1; i < 16; i++) step(0, 8'h00, 0);
        step(1, 8'h06, 0); exp_s("tmo_edge_addr", 4'h0);
        for (int i = 1; i < 16; i++) step(0, 8'h00, 0);
        step(1, 8'h44, 0); exp_f("tmo_edge_wr", 4'h8, 4'h6, 8'h44, 4'h0);
`else
        // Without the timeout the decoder waits indefinitely mid-frame
        step(1, 8'hAA, 0); exp_s("wait_cmd", 4'h0);
        for (int i = 0; i < 40; i++) begin
            step(0, 8'h00, 0); exp_s($sformatf("wait%0d", i), 4'h0);
        end
        step(1, 8'h06, 0); exp_s("wait_addr", 4'h0);
        step(1, 8'h44, 0); exp_f("wait_wr", 4'h8, 4'h6, 8'h44, 4'h0);
`endif
        step(0, 8'h00, 0); exp_s("final_quiet", 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
